a2d_spi_arb: RTL and testbench
==============================

A2D_SPI_ARB -- requirements
Module: a2d_spi_arb

Interface
REQ-001 Parameter: TO_CYCLES, default 1024, number of BUSY cycles without mstr_done before a transaction is aborted.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 req0 / req1  input  1  one-cycle request strobe from client 0 / client 1.
REQ-005 cmd0 / cmd1  input  16  SPI command word of the client, sampled in the cycle its req strobe is high.
REQ-006 lock0 / lock1  input  1  level; when high, the client keeps ownership after done so it can issue a follow-on transaction.
REQ-007 gnt0 / gnt1  output  1  level; high while the client owns the SPI master.
REQ-008 done0 / done1  output  1  one-cycle pulse; the client's transaction has completed.
REQ-009 rd_data  output  16  last completed transaction's read word; shared by both clients.
REQ-010 err  output  1  one-cycle pulse on transaction timeout.
REQ-011 mstr_wrt  output  1  one-cycle start strobe to the SPI master.
REQ-012 mstr_cmd  output  16  command word to the SPI master; held stable from mstr_wrt until the next grant.
REQ-013 mstr_done  input  1  completion pulse from the SPI master.
REQ-014 mstr_rd_data  input  16  read word from the SPI master; valid when mstr_done is high.

Function
REQ-015 Pending:
- Per client, req sets a pend flag and latches cmd into that client's cmd buffer.
- A req arriving while that client's pend is already set is ignored; the buffered cmd is not overwritten.
- The pend flag clears on the edge at which that request is issued.
REQ-016 States are IDLE, BUSY and HOLD; all outputs are registered.
REQ-017 IDLE, issue: if any pend flag is set, at the next edge:
- the arbiter chooses the owner;
- sets gnt_owner=1 and mstr_cmd=owner's cmd buffer;
- sets mstr_wrt=1 for exactly one cycle;
- enters BUSY.
REQ-018 Latency: a req strobe in cycle N produces mstr_wrt high in cycle N+2 when the arbiter is IDLE.
REQ-019 Arbitration is round-robin; the priority pointer points to the client that did not own last.
- If both pend flags are set, the arbiter grants the pointed-to client.
- After reset the pointer favours client 0.
REQ-020 BUSY, on mstr_done=1 at an edge:
- rd_data<=mstr_rd_data;
- done_owner pulses one cycle;
- the timeout counter clears;
- next state is HOLD if lock_owner=1 in that cycle, else IDLE.
REQ-021 Transition BUSY->IDLE:
- gnt_owner drops on the same edge;
- the priority pointer moves to the other client.
REQ-022 HOLD:
- gnt_owner stays high and the other client is never granted.
- If pend_owner is set, the arbiter issues per REQ-017 without re-arbitration.
- Else, if lock_owner=0, it goes to IDLE per REQ-021.
REQ-023 Timeout: a counter increments each BUSY cycle. When it reaches TO_CYCLES without mstr_done:
- err pulses one cycle;
- done_owner is not pulsed and rd_data is unchanged;
- the arbiter goes to IDLE per REQ-021, so any lock is released.
REQ-024 mstr_done outside BUSY is ignored; mstr_done and timeout in the same cycle is treated as done.
REQ-025 The non-owner's req during BUSY/HOLD only sets its pend flag; it is served at the next IDLE arbitration.
REQ-026 gnt0 and gnt1 are never high simultaneously; mstr_wrt is only ever high in the first BUSY cycle.

Reset
REQ-027 rst_n=0 at an edge forces:
- state to IDLE;
- gnt0=gnt1=0, done0=done1=0, err=0, mstr_wrt=0;
- mstr_cmd=16'h0000, rd_data=16'h0000;
- both pend flags, both cmd buffers and the timeout counter cleared;
- the priority pointer to client 0.
REQ-028 Reset mid-BUSY abandons the transaction; a later stray mstr_done produces no done pulse.

Verification
REQ-029 The bench SHALL use the ADC128S model behind an SPI master and cover:
- Single request: req0 with cmd0=16'h0800 -> mstr_wrt one cycle at N+2, mstr_cmd=16'h0800, one done0 pulse, rd_data equals the model's returned word, gnt0 low the cycle after done0.
- Simultaneous requests: req0 and req1 in the same cycle after reset, cmd0=16'h1000, cmd1=16'h1800 -> mstr_cmd sequence 16'h1000 then 16'h1800, done0 before done1, never both gnt high.
- Locked burst: lock0=1, req0 twice (cmd 16'h0000, 16'h0000), req1 strobed during the first BUSY -> mstr_cmd order 0,0 then cmd1 only after lock0 falls; gnt1 stays low throughout HOLD.
- Timeout: TO_CYCLES=64, master held silent -> err pulses exactly 64 BUSY cycles after mstr_wrt, no done, then the pending client 1 is issued.
- Reset mid-BUSY: rst_n low for 1 cycle during BUSY -> all outputs 0 on the next edge; a subsequent mstr_done yields no done0/done1.
- Fairness: both clients re-strobe req on every done for 8 transactions -> grants strictly alternate 0,1,0,1...

Source files
------------

// File: rtl/a2d_spi_arb.sv
// a2d_spi_arb: two-client round-robin arbiter in front of an SPI master, with
// per-client request buffering, ownership lock (HOLD) and a BUSY timeout.
module a2d_spi_arb #(
    parameter int TO_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        mstr_wrt,
    output logic [15:0] mstr_cmd,
    input  logic        mstr_done,
    input  logic [15:0] mstr_rd_data
);

    localparam int CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [15:0]   buf0_q, buf0_d;
    logic [15:0]   buf1_q, buf1_d;
    logic          owner_q, owner_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [15:0]   rd_q, rd_d;
    logic          err_q, err_d;
    logic          wrt_q, wrt_d;
    logic [15:0]   cmd_q, cmd_d;

    logic issue_s, issue_id_s, release_s, done_hit_s, timeout_s, lock_own_s;

    assign lock_own_s = owner_q ? lock1 : lock0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the issue/release/complete decisions
    always_comb begin
        state_d    = state_q;
        issue_s    = 1'b0;
        issue_id_s = owner_q;
        release_s  = 1'b0;
        done_hit_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    issue_s    = 1'b1;
                    issue_id_s = (pend_q == 2'b11) ? ptr_q : pend_q[1];
                    state_d    = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // completion wins over a timeout landing in the same cycle
                if (mstr_done) begin
                    done_hit_s = 1'b1;
                    if (lock_own_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d   = IDLE;
                        release_s = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_s = 1'b1;
                    release_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            HOLD: begin
                if (pend_q[owner_q]) begin
                    issue_s    = 1'b1;
                    issue_id_s = owner_q;
                    state_d    = BUSY;
                end else if (!lock_own_s) begin
                    release_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        if (issue_s && !issue_id_s) begin
            pend_d[0] = 1'b0;
        end else if (req0) begin
            pend_d[0] = 1'b1;
        end else begin
            pend_d[0] = pend_q[0];
        end
        if (issue_s && issue_id_s) begin
            pend_d[1] = 1'b0;
        end else if (req1) begin
            pend_d[1] = 1'b1;
        end else begin
            pend_d[1] = pend_q[1];
        end

        buf0_d  = (req0 && !pend_q[0]) ? cmd0 : buf0_q;
        buf1_d  = (req1 && !pend_q[1]) ? cmd1 : buf1_q;
        owner_d = issue_s ? issue_id_s : owner_q;
        ptr_d   = release_s ? ~owner_q : ptr_q;

        if (issue_s) begin
            gnt_d = issue_id_s ? 2'b10 : 2'b01;
        end else if (release_s) begin
            gnt_d = 2'b00;
        end else begin
            gnt_d = gnt_q;
        end

        if (done_hit_s) begin
            done_d = owner_q ? 2'b10 : 2'b01;
            rd_d   = mstr_rd_data;
        end else begin
            done_d = 2'b00;
            rd_d   = rd_q;
        end

        if (state_q == BUSY && !done_hit_s && !timeout_s) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = {CW{1'b0}};
        end

        err_d = timeout_s;
        wrt_d = issue_s;
        cmd_d = issue_s ? (issue_id_s ? buf1_q : buf0_q) : cmd_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= 2'b00;
            buf0_q  <= 16'h0000;
            buf1_q  <= 16'h0000;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rd_q    <= 16'h0000;
            err_q   <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
        end else begin
            pend_q  <= pend_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign rd_data  = rd_q;
    assign err      = err_q;
    assign mstr_wrt = wrt_q;
    assign mstr_cmd = cmd_q;

endmodule

// File: tb/tb_a2d_spi_arb.sv
// tb_a2d_spi_arb: directed scenarios plus random traffic, every cycle compared
// against a transaction-rule model; an ADC128S-style responder stands in for the SPI master.
module tb_a2d_spi_arb;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [15:0] cmd0 = 16'h0000, cmd1 = 16'h0000;
    logic        mstr_done = 1'b0;
    logic [15:0] mstr_rd_data = 16'h0000;
    logic        gnt0, gnt1, done0, done1, err, mstr_wrt;
    logic [15:0] rd_data, mstr_cmd;

    a2d_spi_arb #(.TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_data(rd_data), .err(err), .mstr_wrt(mstr_wrt), .mstr_cmd(mstr_cmd),
        .mstr_done(mstr_done), .mstr_rd_data(mstr_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ADC128S stand-in: channel from cmd[13:11], 12-bit conversion with 4 leading zeros
    logic [11:0] adc_val [8];
    function automatic logic [15:0] adc_word(input logic [2:0] ch);
        return {4'h0, adc_val[ch]};
    endfunction

    int         rsp_cnt = 0;
    logic [2:0] rsp_ch = 3'd0;
    bit         silent = 1'b0, stray_en = 1'b0;
    int         lat_min = 1, lat_max = 6;

    // SPI master + ADC responder: answers each mstr_wrt after a random latency
    always @(negedge clk) begin
        mstr_done = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mstr_done    = 1'b1;
                mstr_rd_data = adc_word(rsp_ch);
            end
        end
        if (mstr_wrt === 1'b1) begin
            rsp_ch  = mstr_cmd[13:11];
            rsp_cnt = silent ? 0 : int'($urandom_range(lat_max, lat_min));
        end
        if (stray_en && $urandom_range(49, 0) == 0) begin
            mstr_done    = 1'b1;
            mstr_rd_data = 16'($urandom);
        end
    end

    // Reference model: ownership/pending rules at transaction level
    bit          m_pend [2];
    logic [15:0] m_buf [2];
    int          m_owner, m_age, m_ptr;
    bit          m_busy;
    logic [1:0]  m_gnt, m_done;
    logic        m_err, m_wrt;
    logic [15:0] m_cmd, m_rd;

    task automatic model_release();
        m_ptr   = 1 - m_owner;
        m_owner = -1;
        m_busy  = 1'b0;
        m_age   = 0;
    endtask

    task automatic model_step();
        bit req [2];
        bit lk [2];
        bit old [2];
        logic [15:0] c [2];
        int iss;
        req[0] = req0; req[1] = req1; lk[0] = lock0; lk[1] = lock1;
        c[0] = cmd0; c[1] = cmd1; old[0] = m_pend[0]; old[1] = m_pend[1];
        if (!rst_n) begin
            m_pend[0] = 0; m_pend[1] = 0; m_buf[0] = 16'h0; m_buf[1] = 16'h0;
            m_owner = -1; m_busy = 0; m_age = 0; m_ptr = 0;
            m_gnt = 2'b00; m_done = 2'b00; m_err = 0; m_wrt = 0; m_cmd = 16'h0; m_rd = 16'h0;
            return;
        end
        m_done = 2'b00; m_err = 1'b0; m_wrt = 1'b0; iss = -1;
        if (m_owner < 0) begin
            if (old[0] || old[1]) iss = (old[0] && old[1]) ? m_ptr : (old[0] ? 0 : 1);
        end else if (m_busy) begin
            if (mstr_done) begin
                m_rd = mstr_rd_data;
                m_done[m_owner] = 1'b1;
                m_age = 0;
                if (lk[m_owner]) m_busy = 1'b0;
                else model_release();
            end else if (m_age + 1 >= TO) begin
                m_err = 1'b1;
                model_release();
            end else begin
                m_age++;
            end
        end else begin
            if (old[m_owner]) iss = m_owner;
            else if (!lk[m_owner]) model_release();
        end
        if (iss >= 0) begin
            m_owner = iss; m_busy = 1'b1; m_age = 0;
            m_cmd = m_buf[iss]; m_wrt = 1'b1; m_pend[iss] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req[i] && !old[i]) begin
                m_pend[i] = 1'b1;
                m_buf[i]  = c[i];
            end
        end
        m_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    endtask

    int          cyc = 0, last_wrt_cyc = 0, last_err_cyc = 0, err_cnt = 0, gnt1_cnt = 0;
    int          wrt_own [$];
    logic [15:0] wrt_cmd [$];
    int          done_own [$];

    // Per-cycle model step, output comparison and event logging
    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        check_val("gnt", {30'd0, gnt1, gnt0}, {30'd0, m_gnt});
        check_val("done", {30'd0, done1, done0}, {30'd0, m_done});
        check_val("err", {31'd0, err}, {31'd0, m_err});
        check_val("wrt", {31'd0, mstr_wrt}, {31'd0, m_wrt});
        check_val("mstr_cmd", {16'd0, mstr_cmd}, {16'd0, m_cmd});
        check_val("rd_data", {16'd0, rd_data}, {16'd0, m_rd});
        check_val("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
        if (mstr_wrt) begin
            wrt_own.push_back(gnt1 ? 1 : 0);
            wrt_cmd.push_back(mstr_cmd);
            last_wrt_cyc = cyc;
        end
        if (done0) done_own.push_back(0);
        if (done1) done_own.push_back(1);
        if (err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (gnt1) gnt1_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        tick(24);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        wrt_own.delete(); wrt_cmd.delete(); done_own.delete();
        gnt1_cnt = 0; err_cnt = 0;
    endtask

    task automatic strobe(input bit a, input bit b, input logic [15:0] ca, input logic [15:0] cb);
        @(negedge clk);
        req0 = a; req1 = b; cmd0 = ca; cmd1 = cb;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // which: 0 = issued transactions, 1 = completions
    task automatic wait_q(input int which, input int n, input int budget, input string tag);
        int k = 0;
        while (((which == 0) ? wrt_own.size() : done_own.size()) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, (((which == 0) ? wrt_own.size() : done_own.size()) >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int wc, e0, dn, k;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
        tick(2);
        check_val("reset_outs", {gnt1, gnt0, done1, done0, err, mstr_wrt, mstr_cmd, rd_data}, 32'd0);
        rst_n = 1'b1;

        // single request: latency, command, read word, grant drop
        do_reset();
        strobe(1'b1, 1'b0, 16'h0800, 16'h0000);
        check_val("lat_n1", {31'd0, mstr_wrt}, 32'd0);
        @(posedge clk); #1;
        check_val("lat_n2", {31'd0, mstr_wrt}, 32'd1);
        check_val("single_cmd", {16'd0, mstr_cmd}, 32'h0800);
        wait_q(1, 1, 20, "single_done_seen");
        check_val("single_rd", {16'd0, rd_data}, {16'd0, adc_word(3'd1)});
        @(posedge clk); #1;
        check_val("single_gnt_drop", {31'd0, gnt0}, 32'd0);
        tick(8);
        check_val("single_done_cnt", done_own.size(), 32'd1);

        // simultaneous requests
        do_reset();
        strobe(1'b1, 1'b1, 16'h1000, 16'h1800);
        wait_q(1, 2, 40, "simul_done_seen");
        check_val("simul_cmd0", {16'd0, wrt_cmd[0]}, 32'h1000);
        check_val("simul_cmd1", {16'd0, wrt_cmd[1]}, 32'h1800);
        check_val("simul_done_order0", done_own[0], 32'd0);
        check_val("simul_done_order1", done_own[1], 32'd1);

        // locked burst
        do_reset();
        lat_min = 3;
        lock0 = 1'b1;
        strobe(1'b1, 1'b0, 16'h0000, 16'h0000);
        wait_q(0, 1, 10, "lock_wrt1");
        strobe(1'b0, 1'b1, 16'h0000, 16'h2000);
        wait_q(1, 1, 20, "lock_done1");
        strobe(1'b1, 1'b0, 16'h0000, 16'h0000);
        wait_q(1, 2, 30, "lock_done2");
        tick(3);
        check_val("lock_gnt1_low", gnt1_cnt, 32'd0);
        check_val("lock_wrt_cnt_held", wrt_own.size(), 32'd2);
        lock0 = 1'b0;
        wait_q(1, 3, 30, "lock_done3");
        check_val("lock_own0", wrt_own[0], 32'd0);
        check_val("lock_own1", wrt_own[1], 32'd0);
        check_val("lock_own2", wrt_own[2], 32'd1);
        check_val("lock_cmd2", {16'd0, wrt_cmd[2]}, 32'h2000);
        lat_min = 1;

        // timeout
        do_reset();
        silent = 1'b1;
        strobe(1'b1, 1'b0, 16'h0800, 16'h0000);
        wait_q(0, 1, 10, "to_wrt");
        wc = last_wrt_cyc;
        strobe(1'b0, 1'b1, 16'h0000, 16'h1800);
        e0 = err_cnt; k = 0;
        while (err_cnt == e0 && k < 120) begin
            @(negedge clk);
            k++;
        end
        check_val("to_err_seen", err_cnt - e0, 32'd1);
        check_val("to_delay", last_err_cyc - wc, 32'd64);
        check_val("to_no_done", done_own.size(), 32'd0);
        silent = 1'b0;
        wait_q(1, 1, 20, "to_next_done");
        check_val("to_next_own", wrt_own[1], 32'd1);
        check_val("to_next_cmd", {16'd0, wrt_cmd[1]}, 32'h1800);

        // reset mid-BUSY, followed by a stray completion
        do_reset();
        lat_min = 8; lat_max = 8;
        strobe(1'b1, 1'b0, 16'h2800, 16'h0000);
        wait_q(0, 1, 10, "rst_wrt");
        tick(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("rst_mid_outs", {gnt1, gnt0, done1, done0, err, mstr_wrt, mstr_cmd, rd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = done_own.size();
        tick(12);
        check_val("rst_stray_done", done_own.size(), dn);
        lat_min = 1; lat_max = 6;

        // fairness: both clients re-request on every completion
        do_reset();
        strobe(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        k = 0;
        while (wrt_own.size() < 8 && k < 400) begin
            @(negedge clk);
            req0 = done0; req1 = done1;
            cmd0 = 16'($urandom); cmd1 = 16'($urandom);
            k++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check_val("fair_count", (wrt_own.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 8; i++) check_val($sformatf("fair_%0d", i), wrt_own[i], i % 2);

        // random traffic with locks, silent masters, stray completions and resets
        do_reset();
        stray_en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            req0 = ($urandom_range(7, 0) == 0);
            req1 = ($urandom_range(7, 0) == 0);
            cmd0 = 16'($urandom); cmd1 = 16'($urandom);
            if ($urandom_range(19, 0) == 0) lock0 = ~lock0;
            if ($urandom_range(19, 0) == 0) lock1 = ~lock1;
            silent = ($urandom_range(9, 0) == 0);
            rst_n = ($urandom_range(399, 0) != 0);
        end
        stray_en = 1'b0; silent = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; rst_n = 1'b1;
        tick(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
